// File: rtl/aes_pkg.sv
// Shared constants for the MixColumns sequencer: multiplier select codes,
// the circulant coefficient row and the controller state set.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] SEL_ZERO = 2'b00;
    localparam logic [1:0] SEL_X1   = 2'b01;
    localparam logic [1:0] SEL_X2   = 2'b10;
    localparam logic [1:0] SEL_X3   = 2'b11;

    localparam int NUM_TERMS = 16;

    // Row 0 of the MixColumns matrix; row r is this row rotated right by r.
    localparam logic [7:0] COEF [4] = '{8'h02, 8'h03, 8'h01, 8'h01};

    function automatic logic [1:0] coef_sel(input logic [1:0] pos);
        logic [1:0] sel;
        case (COEF[pos])
            8'h01:   sel = SEL_X1;
            8'h02:   sel = SEL_X2;
            8'h03:   sel = SEL_X3;
            default: sel = SEL_ZERO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/gf_mult_sel.sv
// GF(2^8) multiply by a small constant (0, 1, 2 or 3), polynomial 0x11B.
module gf_mult_sel
    import aes_pkg::*;
(
    input  logic [7:0] in,
    input  logic [1:0] select,
    output logic [7:0] out
);

    logic [7:0] x2;

    assign x2 = {in[6:0], 1'b0} ^ (in[7] ? 8'h1B : 8'h00);

    always_comb begin
        out = 8'h00;
        case (select)
            SEL_ZERO: out = 8'h00;
            SEL_X1:   out = in;
            SEL_X2:   out = x2;
            SEL_X3:   out = x2 ^ in;
            default:  out = 8'h00;
        endcase
    end

endmodule

// File: rtl/mixcol_seq.sv
// Sequential AES MixColumns on one 32-bit column using a single shared
// GF multiplier over 16 cycles. Define MIXCOL_CNT_EN to add the col_cnt output.
module mixcol_seq
    import aes_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] col_in,
    output logic        out_valid,
    input  logic        out_ready,
`ifdef MIXCOL_CNT_EN
    output logic [15:0] col_cnt,
`endif
    output logic [31:0] col_out,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_CALC = CALC;
    localparam logic [1:0] ST_DONE = DONE;
    localparam logic [3:0] IDX_LAST = 4'(NUM_TERMS - 1);

    logic [1:0]  state;
    logic [3:0]  idx;
    logic [7:0]  acc;
    logic [31:0] cap;
    logic [23:0] res;
    logic [1:0]  row;
    logic [1:0]  term;
    logic [7:0]  a_byte;
    logic [7:0]  product;
    logic [7:0]  acc_next;

    assign row  = idx[3:2];
    assign term = idx[1:0];

    always_comb begin
        a_byte = 8'h00;
        case (term)
            2'd0:    a_byte = cap[31:24];
            2'd1:    a_byte = cap[23:16];
            2'd2:    a_byte = cap[15:8];
            default: a_byte = cap[7:0];
        endcase
    end

    gf_mult_sel u_mult (
        .in     (a_byte),
        .select (coef_sel(term - row)),
        .out    (product)
    );

    assign acc_next  = acc ^ product;
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);

    // Bytes 0..2 collect in res; byte 3 lands together with the DONE entry so
    // that col_out only ever changes on that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            idx     <= 4'd0;
            acc     <= 8'h00;
            cap     <= 32'h0;
            res     <= 24'h0;
            col_out <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        cap   <= col_in;
                        idx   <= 4'd0;
                        acc   <= 8'h00;
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    idx <= idx + 4'd1;
                    if (term == 2'd3) begin
                        acc <= 8'h00;
                        case (row)
                            2'd0:    res[23:16] <= acc_next;
                            2'd1:    res[15:8]  <= acc_next;
                            2'd2:    res[7:0]   <= acc_next;
                            default: ;
                        endcase
                    end else begin
                        acc <= acc_next;
                    end
                    if (idx == IDX_LAST) begin
                        col_out <= {res, acc_next};
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef MIXCOL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      col_cnt <= 16'h0;
        else if (out_valid && out_ready) col_cnt <= col_cnt + 16'h1;
    end
`endif

endmodule

// File: tb/tb_mixcol_seq.sv
// Self-checking bench for mixcol_seq against a behavioural MixColumns model.
module tb_mixcol_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] col_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] col_out;
    logic        busy;
`ifdef MIXCOL_CNT_EN
    logic [15:0] col_cnt;
`endif

    logic [7:0] m_in;
    logic [1:0] m_sel;
    logic [7:0] m_out;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int exp_hs = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mixcol_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .col_in    (col_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef MIXCOL_CNT_EN
        .col_cnt   (col_cnt),
`endif
        .col_out   (col_out),
        .busy      (busy)
    );

    gf_mult_sel u_mult_chk (
        .in     (m_in),
        .select (m_sel),
        .out    (m_out)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? (8'(x << 1) ^ 8'h1B) : 8'(x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [31:0] mixcol(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] b [4];
        int coef [4] = '{2, 3, 1, 1};
        for (int k = 0; k < 4; k++) a[k] = c[31 - 8*k -: 8];
        for (int r = 0; r < 4; r++) begin
            b[r] = 8'h00;
            for (int k = 0; k < 4; k++)
                b[r] = b[r] ^ gmul(a[k], 8'(coef[(k - r + 4) % 4]));
        end
        return {b[0], b[1], b[2], b[3]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, output bit ok);
        for (int i = 0; i < 40 && !out_valid; i++) step();
        ok = out_valid;
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL %s: out_valid timeout, got 0 need 1", name);
        end
    endtask

    task automatic run_col(input string name, input logic [31:0] col,
                           input logic [31:0] expv, input int delay);
        int t_acc;
        bit ok;
        for (int i = 0; i < 40 && !in_ready; i++) step();
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s: in_ready timeout, got %b need 1", name, in_ready);
        end
        in_valid = 1'b1;
        col_in   = col;
        step();
        t_acc    = cyc;
        in_valid = 1'b0;
        col_in   = $urandom;
        wait_valid(name, ok);
        if (ok) begin
            tests++;
            if (cyc - t_acc !== 16) begin
                fails++;
                $display("FAIL %s latency: got %0d need 16", name, cyc - t_acc);
            end
            tests++;
            if (col_out !== expv) begin
                fails++;
                $display("FAIL %s col_out: got %h need %h (in %h)", name, col_out, expv, col);
            end
            repeat (delay) step();
            out_ready = 1'b1;
            step();
            exp_hs++;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; col_in = 32'h0;
        m_in = 8'h00; m_sel = 2'b00;
        #2;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || col_out !== 32'h0) begin
            fails++;
            $display("FAIL reset outputs: got rdy=%b vld=%b busy=%b out=%h need 1 0 0 00000000",
                     in_ready, out_valid, busy, col_out);
        end
        repeat (3) step();
        in_valid = 1'b1;
        col_in   = 32'hDB135345;
        #2 rst_n = 1'b1;
        step();
        in_valid = 1'b0;
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL first_edge_accept: busy got %b need 1", busy);
        end
    endtask

    task automatic test_known_vector();
        bit ok;
        wait_valid("known_db13", ok);
        if (ok) begin
            tests++;
            if (col_out !== 32'h8E4DA1BC) begin
                fails++;
                $display("FAIL known_db13: got %h need 8e4da1bc", col_out);
            end
            out_ready = 1'b1; step(); exp_hs++; out_ready = 1'b0;
        end
        run_col("known_db13_lat", 32'hDB135345, 32'h8E4DA1BC, 0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] cols [2] = '{32'hD4BF5D30, 32'hF20A225C};
        logic [31:0] need [2] = '{32'h046681E5, 32'h9FDC589D};
        logic [31:0] got  [2];
        int acc_t [2];
        int na = 0;
        int nr = 0;
        bit pre;
        in_valid = 1'b1; col_in = cols[0]; out_ready = 1'b1;
        for (int i = 0; i < 80 && nr < 2; i++) begin
            pre = in_ready && in_valid;
            step();
            if (pre && na < 2) begin
                acc_t[na] = cyc;
                na++;
                if (na < 2) col_in = cols[na];
                else in_valid = 1'b0;
            end
            if (out_valid && nr < 2) begin
                got[nr] = col_out;
                nr++;
                exp_hs++;
            end
        end
        step();
        out_ready = 1'b0; in_valid = 1'b0;
        tests++;
        if (nr !== 2 || na !== 2) begin
            fails++;
            $display("FAIL b2b count: got acc=%0d res=%0d need 2 2", na, nr);
        end else begin
            for (int j = 0; j < 2; j++) begin
                tests++;
                if (got[j] !== need[j]) begin
                    fails++;
                    $display("FAIL b2b result%0d: got %h need %h", j, got[j], need[j]);
                end
            end
            tests++;
            if (acc_t[1] - acc_t[0] !== 18) begin
                fails++;
                $display("FAIL b2b spacing: got %0d need 18", acc_t[1] - acc_t[0]);
            end
        end
    endtask

    task automatic test_identity();
        run_col("identity_01", 32'h01010101, 32'h01010101, 1);
        run_col("identity_c6", 32'hC6C6C6C6, 32'hC6C6C6C6, 2);
    endtask

    task automatic test_stall();
        logic [31:0] col = $urandom;
        logic [31:0] hold;
        bit ok;
        for (int i = 0; i < 40 && !in_ready; i++) step();
        in_valid = 1'b1; col_in = col; step(); in_valid = 1'b0;
        wait_valid("stall", ok);
        if (!ok) return;
        hold = col_out;
        tests++;
        if (hold !== mixcol(col)) begin
            fails++;
            $display("FAIL stall result: got %h need %h", hold, mixcol(col));
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2 == 0);
            col_in   = $urandom;
            step();
            tests++;
            if (col_out !== hold || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                fails++;
                $display("FAIL stall cycle%0d: got out=%h rdy=%b vld=%b need %h 0 1",
                         i, col_out, in_ready, out_valid, hold);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        exp_hs++;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || col_out !== hold) begin
                fails++;
                $display("FAIL post_stall%0d: got rdy=%b busy=%b vld=%b out=%h need 1 0 0 %h",
                         i, in_ready, busy, out_valid, col_out, hold);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic [31:0] col = $urandom;
        int seen = 0;
`ifdef MIXCOL_CNT_EN
        tests++;
        if (col_cnt !== 16'(exp_hs)) begin
            fails++;
            $display("FAIL col_cnt: got %0d need %0d", col_cnt, exp_hs);
        end
`endif
        for (int i = 0; i < 40 && !in_ready; i++) step();
        in_valid = 1'b1; col_in = col; step(); in_valid = 1'b0;
        repeat (7) step();
        #2 rst_n = 1'b0;
        #1;
        exp_hs = 0;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || col_out !== 32'h0) begin
            fails++;
            $display("FAIL mid_reset async: got rdy=%b vld=%b busy=%b out=%h need 1 0 0 00000000",
                     in_ready, out_valid, busy, col_out);
        end
`ifdef MIXCOL_CNT_EN
        tests++;
        if (col_cnt !== 16'h0) begin
            fails++;
            $display("FAIL col_cnt reset: got %0d need 0", col_cnt);
        end
`endif
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (out_valid) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL mid_reset stray out_valid: got %0d cycles need 0", seen);
        end
        run_col("after_reset", 32'hDB135345, 32'h8E4DA1BC, 0);
    endtask

    task automatic test_random();
        logic [31:0] c;
        for (int i = 0; i < 12; i++) begin
            c = $urandom;
            run_col("random", c, mixcol(c), $urandom_range(0, 3));
        end
`ifdef MIXCOL_CNT_EN
        tests++;
        if (col_cnt !== 16'(exp_hs)) begin
            fails++;
            $display("FAIL col_cnt final: got %0d need %0d", col_cnt, exp_hs);
        end
`endif
    endtask

    task automatic test_mult();
        logic [7:0] need [4] = '{8'h00, 8'hA7, 8'h55, 8'hF2};
        logic [7:0] r;
        for (int s = 0; s < 4; s++) begin
            m_in = 8'hA7; m_sel = 2'(s);
            #1;
            tests++;
            if (m_out !== need[s]) begin
                fails++;
                $display("FAIL mult_a7 sel%0d: got %h need %h", s, m_out, need[s]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            r = 8'($urandom);
            m_in = r; m_sel = 2'($urandom_range(0, 3));
            #1;
            tests++;
            if (m_out !== gmul(r, {6'h0, m_sel})) begin
                fails++;
                $display("FAIL mult_rand: in %h sel %0d got %h need %h",
                         r, m_sel, m_out, gmul(r, {6'h0, m_sel}));
            end
        end
    endtask

    initial begin
        test_reset();
        test_known_vector();
        test_back_to_back();
        test_identity();
        test_stall();
        test_mid_reset();
        test_random();
        test_mult();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mixcol_seq.md
MIXCOL_SEQ -- requirements
Module: mixcol_seq

Interface
REQ-001 Parameter: none; all sizing comes from the shared package constants.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  a column is offered on col_in.
REQ-005 in_ready  output  1  the block accepts a column this cycle.
REQ-006 col_in  input  32  state column; byte a0 = [31:24], a1 = [23:16], a2 = [15:8], a3 = [7:0].
REQ-007 out_valid  output  1  col_out holds a finished MixColumns result.
REQ-008 out_ready  input  1  the consumer takes col_out this cycle.
REQ-009 col_out  output  32  result column; byte b0 = [31:24] ... b3 = [7:0].
REQ-010 busy  output  1  high in CALC and DONE.

Function
REQ-011 The block SHALL compute b_r = XOR over k of (M[r][k] · a_k) in GF(2^8), reduction polynomial 0x11B.
- M[r][k] = COEF[(k - r) mod 4].
- COEF = {2, 3, 1, 1}.
REQ-012 The block SHALL use exactly one GF multiplier instance, time-shared over 16 cycles.
REQ-013 The FSM SHALL have states IDLE, CALC and DONE.
REQ-014 IDLE SHALL drive in_ready = 1.
- When in_valid = 1: capture col_in, clear idx[3:0] and acc[7:0], and go to CALC.
REQ-015 In CALC, each cycle idx = 4r + k SHALL perform the following:
- Drive the multiplier with a_k and select = SEL(COEF[(k - r) mod 4]).
- Update acc <= acc ^ product.
REQ-016 When k = 3, the block SHALL write acc ^ product into result byte r and clear acc.
REQ-017 At idx = 15 the block SHALL go to DONE; idx wraps to 0.
REQ-018 DONE SHALL drive out_valid = 1 and hold col_out stable until out_ready = 1, then go to IDLE.
REQ-019 Latency SHALL be fixed: a column accepted at edge T produces out_valid = 1 after edge T+16.
- Throughput SHALL be one column per 18 cycles when out_ready is held at 1.
REQ-020 in_ready SHALL be 0 in CALC and DONE.
- in_valid asserted in those states SHALL be ignored.
- col_in SHALL NOT be re-sampled in those states.
REQ-021 A DONE cycle with out_ready = 1 and in_valid = 1 at the same time SHALL NOT accept the new column.
- The new column is accepted in the following IDLE cycle.
REQ-022 out_ready asserted outside DONE SHALL have no effect.
REQ-023 col_out SHALL change only when DONE is entered.

Reset
REQ-024 When rst_n = 0, the block SHALL immediately enter IDLE and apply these values:
- in_ready = 1, out_valid = 0, busy = 0.
- col_out = 0, idx = 0, acc = 0, captured column = 0.
REQ-025 Reset mid-CALC or mid-DONE SHALL discard the column in flight and SHALL NOT assert out_valid for it.
REQ-026 After rst_n deasserts, the first rising edge SHALL be able to accept a column.

Configuration
REQ-027 With macro MIXCOL_CNT_EN defined, the block SHALL add output port col_cnt [15:0].
- col_cnt is reset to 0.
- It increments on each DONE handshake (out_valid & out_ready).
- It wraps from 0xFFFF to 0x0000.
REQ-028 Without MIXCOL_CNT_EN, the col_cnt port and its counter SHALL be absent; all other behaviour is unchanged.

Structure
REQ-029 Package aes_pkg SHALL hold the following:
- The multiplier select encoding: SEL_ZERO = 2'b00, SEL_X1 = 2'b01, SEL_X2 = 2'b10, SEL_X3 = 2'b11.
- The COEF table.
- The state enum {IDLE, CALC, DONE}.
- The constant NUM_TERMS = 16.
REQ-030 The multiplier SHALL be the sub-module gf_mult_sel, which is purely combinational (in[7:0], select[1:0] -> out[7:0]).
- It is instantiated once.

Verification
REQ-031 Drive col_in = 0xDB135345 -> col_out = 0x8E4DA1BC, with out_valid rising 16 cycles after acceptance.
REQ-032 Drive col_in = 0xD4BF5D30 and then 0xF20A225C back-to-back, with out_ready = 1.
- Required results: 0x046681E5, then 0x9FDC589D.
- Required spacing: 18 cycles between the two acceptances.
REQ-033 Drive col_in = 0x01010101 and then 0xC6C6C6C6 -> each result equals its input.
REQ-034 Hold out_ready = 0 for 10 cycles in DONE, and toggle in_valid during that time.
- col_out SHALL stay constant, in_ready SHALL stay 0, and no new capture SHALL occur.
REQ-035 Pulse rst_n = 0 at CALC idx = 7 -> outputs return to reset values asynchronously, and no out_valid occurs.
- A subsequent column SHALL then compute correctly.
REQ-036 Check the multiplier alone with in = 0xA7:
- SEL_ZERO -> 0x00.
- SEL_X1 -> 0xA7.
- SEL_X2 -> 0x55.
- SEL_X3 -> 0xF2.
- With MIXCOL_CNT_EN defined, col_cnt SHALL equal the number of handshakes.
